// File: rtl/pwm_duty_sequencer.sv
// Glitch-free duty sequencer: maps samples to a PWM compare word and loads it only at period_end.
// Optional slew limiting of compare changes is enabled by defining SLEW_LIMIT_EN.
module pwm_duty_sequencer #(
   parameter int               DATA_W    = 29,
   parameter int               CMP_W     = 12,
   parameter logic [CMP_W-1:0] RESET_CMP = 12'h800,
   parameter logic [CMP_W-1:0] SLEW_STEP = 12'd64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              period_end,
   output logic [CMP_W-1:0]  compare,
   output logic              upd_pulse,
   output logic              ovf
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state, state_nxt;
   logic [CMP_W-1:0] target, goal, cmp_nxt, mapped;
   logic             sat, accept, upd;

   // Sample bits above the sign must all match it, else the value is out of range
   always_comb begin
      sat = (in_data[DATA_W-1:16] != {(DATA_W-16){in_data[15]}});
      if (sat)
         mapped = in_data[DATA_W-1] ? '0 : '1;
      else
         mapped = {~in_data[15], in_data[14:4]};
   end

   assign goal = en ? target : RESET_CMP;

`ifdef SLEW_LIMIT_EN
   logic unused_bits;
   assign unused_bits = ^in_data[3:0];

   always_comb begin
      cmp_nxt = goal;
      if (goal > compare && (goal - compare) > SLEW_STEP)
         cmp_nxt = compare + SLEW_STEP;
      else if (goal < compare && (compare - goal) > SLEW_STEP)
         cmp_nxt = compare - SLEW_STEP;
   end
`else
   logic unused_bits;
   assign unused_bits = ^{in_data[3:0], SLEW_STEP};
   assign cmp_nxt     = goal;
`endif

   assign upd = period_end && (cmp_nxt != compare);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = en;
            accept   = in_valid && en;
            if (accept)
               state_nxt = HOLD;
         end
         HOLD: begin
            if (period_end && cmp_nxt == target)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!en)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         compare   <= RESET_CMP;
         target    <= RESET_CMP;
         upd_pulse <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         upd_pulse <= upd;
         if (upd)
            compare <= cmp_nxt;
         if (!en)
            target <= RESET_CMP;
         else if (accept)
            target <= mapped;
         if (accept && sat)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pwm_duty_sequencer;

`ifdef SLEW_LIMIT_EN
   localparam int STEP = 64;
`else
   localparam int STEP = 4096;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        in_valid = 1'b0;
   logic [28:0] in_data = '0;
   logic        in_ready;
   logic        period_end = 1'b0;
   logic [11:0] compare;
   logic        upd_pulse;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   int m_cmp  = 'h800;
   int m_tgt  = 'h800;
   bit m_busy = 1'b0;
   bit m_ovf  = 1'b0;
   bit m_upd  = 1'b0;

   pwm_duty_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .period_end (period_end),
      .compare    (compare),
      .upd_pulse  (upd_pulse),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [28:0] data;
      logic [11:0] exp_cmp;
      logic        exp_ovf;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Signed sample scaled by 1/16, clamped to 12-bit signed, offset to midscale
   function automatic int map_ref(input logic [28:0] d, output bit sat);
      int s, v;
      s = d[28] ? int'(d) - (1 << 29) : int'(d);
      v = s >>> 4;
      sat = (v > 2047) || (v < -2048);
      if (v > 2047) v = 2047;
      if (v < -2048) v = -2048;
      return v + 2048;
   endfunction

   function automatic int slew_ref(input int c, input int g);
      int diff;
      diff = g - c;
      if (diff > STEP) diff = STEP;
      if (diff < -STEP) diff = -STEP;
      return c + diff;
   endfunction

   task automatic model_edge();
      bit acc, sat;
      int goal, nc, mv;
      if (rst) begin
         m_cmp = 'h800; m_tgt = 'h800; m_busy = 0; m_ovf = 0; m_upd = 0;
         return;
      end
      acc  = in_valid && en && !m_busy;
      goal = en ? m_tgt : 'h800;
      nc   = period_end ? slew_ref(m_cmp, goal) : m_cmp;
      m_upd = (nc != m_cmp);
      if (m_busy && period_end && nc == m_tgt) m_busy = 0;
      m_cmp = nc;
      mv = map_ref(in_data, sat);
      if (!en) begin
         m_busy = 0;
         m_tgt  = 'h800;
      end else if (acc) begin
         m_tgt  = mv;
         m_busy = 1;
         if (sat) m_ovf = 1;
      end
   endtask

   task automatic step(input logic e, input logic v, input logic [28:0] d, input logic pe);
      @(negedge clk);
      en = e; in_valid = v; in_data = d; period_end = pe;
      #1;
      if (!rst) check("in_ready", int'(in_ready), int'(e && !m_busy));
      model_edge();
      @(posedge clk);
      #1;
      check("compare", int'(compare), m_cmp);
      check("upd_pulse", int'(upd_pulse), int'(m_upd));
      check("ovf", int'(ovf), int'(m_ovf));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   // Accept a sample, then run periods until the model says the load completed
   task automatic load(input logic [28:0] d);
      step(1'b1, 1'b1, d, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      for (int p = 0; p < 80 && m_busy; p++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         step(1'b1, 1'b0, '0, 1'b0);
      end
   endtask

   initial begin
      vec_t vecs[8];
      logic [28:0] d;
      vecs[0] = '{29'h0000_0120, 12'h812, 1'b0};
      vecs[1] = '{29'h1FFF_8FF0, 12'h0FF, 1'b0};
      vecs[2] = '{29'h0000_7FF0, 12'hFFF, 1'b0};
      vecs[3] = '{29'h1FFF_8000, 12'h000, 1'b0};
      vecs[4] = '{29'h0000_0000, 12'h800, 1'b0};
      vecs[5] = '{29'h1FFF_FFFF, 12'h7FF, 1'b0};
      vecs[6] = '{29'h0001_0000, 12'hFFF, 1'b1};
      vecs[7] = '{29'h1FFE_0000, 12'h000, 1'b1};

      do_reset();
      check("reset_cmp", int'(compare), 'h800);
      check("reset_ready", int'(in_ready), 1);

      foreach (vecs[i]) begin
         load(vecs[i].data);
         check("vec_cmp", int'(compare), int'(vecs[i].exp_cmp));
         check("vec_ovf", int'(ovf), int'(vecs[i].exp_ovf));
         check("vec_ready", int'(in_ready), 1);
      end

      // Latency: held sample loads only on the first later period_end
      do_reset();
      step(1'b1, 1'b1, 29'h0000_0120, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 1'b1, 29'h0000_0120, 1'b0);
         check("hold_ready", int'(in_ready), 0);
         check("hold_cmp", int'(compare), 'h800);
      end
      step(1'b1, 1'b0, '0, 1'b1);
      check("lat_cmp", int'(compare), 'h812);
      check("lat_pulse", int'(upd_pulse), 1);
      step(1'b1, 1'b0, '0, 1'b0);
      check("lat_pulse_end", int'(upd_pulse), 0);
      check("lat_ready", int'(in_ready), 1);

      // Accept coincident with period_end: wrap is not used
      do_reset();
      step(1'b1, 1'b1, 29'h0000_2000, 1'b1);
      check("same_pe_cmp", int'(compare), 'h800);
      check("same_pe_pulse", int'(upd_pulse), 0);
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1);
`ifdef SLEW_LIMIT_EN
      check("next_pe_cmp", int'(compare), 'h840);
`else
      check("next_pe_cmp", int'(compare), 'hA00);
`endif

      // en dropped in HOLD discards the pending target
      do_reset();
      load(29'h0000_0120);
      step(1'b1, 1'b1, 29'h0000_2000, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 29'h0000_4000, 1'b1);
      check("dis_cmp", int'(compare), 'h800);
      check("dis_pulse", int'(upd_pulse), 1);
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 1'b1, 29'h0000_4000, c[0]);
         check("dis_ready", int'(in_ready), 0);
         check("dis_hold", int'(compare), 'h800);
      end

      // Reset during HOLD clears target, compare and sticky ovf
      do_reset();
      step(1'b1, 1'b1, 29'h0001_0000, 1'b0);
      check("ovf_set", int'(ovf), 1);
      rst = 1'b1;
      step(1'b1, 1'b0, '0, 1'b1);
      rst = 1'b0;
      check("rst_cmp", int'(compare), 'h800);
      check("rst_ovf", int'(ovf), 0);
      step(1'b1, 1'b0, '0, 1'b1);
      check("rst_no_load", int'(compare), 'h800);

`ifdef SLEW_LIMIT_EN
      begin
         int exp_seq[4];
         exp_seq = '{'h840, 'h880, 'h8C0, 'h900};
         do_reset();
         step(1'b1, 1'b1, 29'h0000_1000, 1'b0);
         foreach (exp_seq[k]) begin
            step(1'b1, 1'b0, '0, 1'b1);
            check("slew_cmp", int'(compare), exp_seq[k]);
            check("slew_pulse", int'(upd_pulse), 1);
            step(1'b1, 1'b0, '0, 1'b0);
         end
         check("slew_ready", int'(in_ready), 1);
      end
`endif

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         d = 29'($urandom);
         if ($urandom_range(3) != 0) d[28:16] = {13{d[15]}};
         rst = ($urandom_range(299) == 0);
         step(($urandom_range(15) != 0), 1'($urandom), d,
              ($urandom_range(5) == 0));
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
